// File: rtl/net_strength_resolve_monitor.sv
// Purpose: resolves NDRV strength-annotated drivers on one wire to a 4-state
//   value plus winning strength each cycle, then a monitor FSM checks that the
//   registered resolved state settles to an expected state (pass) before a
//   timeout (fail).
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   drv_en/drv_val      per-driver enable and driven value
//   drv_str0/drv_str1   per-driver 3-bit strengths when driving 0 / 1
//   start, expect_st    arm the monitor; expected state 00=0 01=1 10=z 11=x
//   res_st, res_str     registered resolved state and winning strength
//   busy, done          monitor in ARMED/COUNT, monitor in DONE
//   pass, fail          verdict, valid while done
module net_strength_resolve_monitor #(
  parameter int unsigned NDRV    = 2,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NDRV-1:0]   drv_en,
  input  logic [NDRV-1:0]   drv_val,
  input  logic [3*NDRV-1:0] drv_str0,
  input  logic [3*NDRV-1:0] drv_str1,
  input  logic              start,
  input  logic [1:0]        expect_st,
  output logic [1:0]        res_st,
  output logic [2:0]        res_str,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_0 = 2'b00;
  localparam logic [1:0] ST_1 = 2'b01;
  localparam logic [1:0] ST_Z = 2'b10;
  localparam logic [1:0] ST_X = 2'b11;

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      res_st_q, res_st_d;
  logic [2:0]      res_str_q, res_str_d;
  logic [1:0]      exp_q, exp_d;
  logic [CW-1:0]   scnt_q, scnt_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;

  logic [2:0]      m0, m1;
  logic [2:0]      s0, s1;
  logic            match;
  logic [CW-1:0]   scnt_nxt;
  logic [CW-1:0]   tcnt_inc;

  // Strongest 0-drive and strongest 1-drive; strength 0 is highz and never wins.
  always_comb begin
    m0 = 3'd0;
    m1 = 3'd0;
    s0 = 3'd0;
    s1 = 3'd0;
    for (int i = 0; i < NDRV; i++) begin
      s0 = drv_str0[3*i +: 3];
      s1 = drv_str1[3*i +: 3];
      if (drv_en[i] && !drv_val[i] && (s0 > m0)) m0 = s0;
      if (drv_en[i] &&  drv_val[i] && (s1 > m1)) m1 = s1;
    end
    if ((m0 == 3'd0) && (m1 == 3'd0)) begin
      res_st_d  = ST_Z;
      res_str_d = 3'd0;
    end else if (m0 > m1) begin
      res_st_d  = ST_0;
      res_str_d = m0;
    end else if (m1 > m0) begin
      res_st_d  = ST_1;
      res_str_d = m1;
    end else begin
      res_st_d  = ST_X;
      res_str_d = m0;
    end
  end

  // Monitor next-state; settle completion takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    scnt_d   = scnt_q;
    tcnt_d   = tcnt_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    match    = (res_st_q == exp_q);
    tcnt_inc = tcnt_q + CW'(1);
    scnt_nxt = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ARMED;
          exp_d   = expect_st;
          scnt_d  = '0;
          tcnt_d  = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      ARMED, COUNT: begin
        tcnt_d = tcnt_inc;
        if (match) scnt_nxt = (state_q == ARMED) ? CW'(1) : scnt_q + CW'(1);
        scnt_d = scnt_nxt;
        if (match && (scnt_nxt == CW'(SETTLE))) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else if (tcnt_inc == CW'(TIMEOUT)) begin
          state_d = DONE;
          fail_d  = 1'b1;
        end else begin
          state_d = match ? COUNT : ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ARMED) || (state_d == COUNT);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      res_st_q  <= ST_Z;
      res_str_q <= 3'd0;
      exp_q     <= ST_Z;
      scnt_q    <= '0;
      tcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_st_q  <= res_st_d;
      res_str_q <= res_str_d;
      exp_q     <= exp_d;
      scnt_q    <= scnt_d;
      tcnt_q    <= tcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
    end
  end

  assign res_st  = res_st_q;
  assign res_str = res_str_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_net_strength_resolve_monitor.sv
// Directed bench for net_strength_resolve_monitor (NDRV=2, SETTLE=4, TIMEOUT=64).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_net_strength_resolve_monitor;

  logic       clk;
  logic       rst;
  logic [1:0] drv_en;
  logic [1:0] drv_val;
  logic [5:0] drv_str0;
  logic [5:0] drv_str1;
  logic       start;
  logic [1:0] expect_st;
  logic [1:0] res_st;
  logic [2:0] res_str;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail;

  int n_cmp;
  int n_err;

  net_strength_resolve_monitor #(
    .NDRV(2), .SETTLE(4), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rst(rst),
    .drv_en(drv_en), .drv_val(drv_val),
    .drv_str0(drv_str0), .drv_str1(drv_str1),
    .start(start), .expect_st(expect_st),
    .res_st(res_st), .res_str(res_str),
    .busy(busy), .done(done), .pass(pass), .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge; on return we are 1 unit past that edge (E0).
  task automatic arm(input logic [1:0] e);
    start     = 1'b1;
    expect_st = e;
    step(1);
    start     = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic b, input logic d,
                           input logic p, input logic f);
    chk({tag, "_busy"}, 8'(busy), 8'(b));
    chk({tag, "_done"}, 8'(done), 8'(d));
    chk({tag, "_pass"}, 8'(pass), 8'(p));
    chk({tag, "_fail"}, 8'(fail), 8'(f));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    drv_en    = 2'b00;
    drv_val   = 2'b00;
    drv_str0  = 6'd0;
    drv_str1  = 6'd0;
    start     = 1'b0;
    expect_st = 2'b00;

    // Reset values
    #3;
    chk("rst_res_st", 8'(res_st), 8'd2);
    chk("rst_res_str", 8'(res_str), 8'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;

    // T1: val=1 with highz1, weak0 unused -> z; expect z, pass after SETTLE edges
    drv_en   = 2'b11;
    drv_val  = 2'b11;
    drv_str0 = {3'd3, 3'd3};
    drv_str1 = {3'd0, 3'd0};
    arm(2'b10);
    chk("t1_res_st", 8'(res_st), 8'd2);
    chk("t1_res_str", 8'(res_str), 8'd0);
    chk_flags("t1_armed", 1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    chk_flags("t1_e3", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_flags("t1_e4", 1'b0, 1'b1, 1'b1, 1'b0);
    step(2);
    chk_flags("t1_hold", 1'b0, 1'b1, 1'b1, 1'b0);

    // T2: strong1 vs pull0 -> 1 @6; re-arm from DONE clears pass
    drv_en   = 2'b11;
    drv_val  = 2'b01;
    drv_str0 = {3'd5, 3'd0};
    drv_str1 = {3'd0, 3'd6};
    arm(2'b01);
    chk("t2_res_st", 8'(res_st), 8'd1);
    chk("t2_res_str", 8'(res_str), 8'd6);
    chk_flags("t2_rearm", 1'b1, 1'b0, 1'b0, 1'b0);
    step(4);
    chk_flags("t2_e4", 1'b0, 1'b1, 1'b1, 1'b0);

    // T3: pull1 vs pull0 -> x @5; expect 0 never matches -> fail at TIMEOUT
    drv_val  = 2'b01;
    drv_str0 = {3'd5, 3'd0};
    drv_str1 = {3'd0, 3'd5};
    arm(2'b00);
    chk("t3_res_st", 8'(res_st), 8'd3);
    chk("t3_res_str", 8'(res_str), 8'd5);
    step(63);
    chk_flags("t3_e63", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_flags("t3_e64", 1'b0, 1'b1, 1'b0, 1'b1);

    // T4: expect z; one-cycle glitch to 1 restarts the settle count
    drv_en   = 2'b00;
    drv_val  = 2'b00;
    drv_str0 = 6'd0;
    drv_str1 = 6'd0;
    arm(2'b10);
    step(2);
    drv_en   = 2'b01;
    drv_val  = 2'b01;
    drv_str1 = {3'd0, 3'd6};
    step(1);
    chk("t4_glitch_st", 8'(res_st), 8'd1);
    drv_en = 2'b00;
    step(1);
    chk_flags("t4_e4", 1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    chk_flags("t4_e7", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk_flags("t4_e8", 1'b0, 1'b1, 1'b1, 1'b0);

    // T5: async reset in COUNT, then a normal run
    drv_en   = 2'b01;
    drv_val  = 2'b01;
    drv_str1 = {3'd0, 3'd6};
    arm(2'b01);
    step(2);
    chk("t5_pre_res_st", 8'(res_st), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_res_st", 8'(res_st), 8'd2);
    chk("t5_rst_res_str", 8'(res_str), 8'd0);
    chk_flags("t5_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    step(1);
    arm(2'b01);
    chk("t5_run_res_st", 8'(res_st), 8'd1);
    step(4);
    chk_flags("t5_run", 1'b0, 1'b1, 1'b1, 1'b0);

    // T6: no drivers -> z @0; start while busy must not relatch expect
    drv_en = 2'b00;
    step(1);
    chk("t6_res_st", 8'(res_st), 8'd2);
    chk("t6_res_str", 8'(res_str), 8'd0);
    arm(2'b00);
    step(1);
    arm(2'b10);
    step(8);
    chk_flags("t6_e10", 1'b1, 1'b0, 1'b0, 1'b0);
    step(54);
    chk_flags("t6_e64", 1'b0, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
